fan_tach_counter: RTL and testbench



---
 rtl/fan_tach_counter.sv | 137 +++++++++++++
 tb/tb_fan_tach_counter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fan_tach_counter.sv
// ============================================================================
// Module   : fan_tach_counter
// Purpose  : Gated-window fan tachometer producing a saturated 16-bit RPM value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_tach_counter #(
  parameter int REFCLK_HZ      = 250000000,
  parameter int PULSES_PER_REV = 2,
  parameter int FILTER_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tach,
  output logic [15:0] rpm,
  output logic        rpm_valid,
  output logic        stalled
);

  localparam int STABLE_W  = $clog2(FILTER_CYCLES + 1);
  localparam int WIN_W     = (REFCLK_HZ > 1) ? $clog2(REFCLK_HZ) : 1;
  localparam int PPR_SHIFT = (PULSES_PER_REV == 4) ? 2 : ((PULSES_PER_REV == 2) ? 1 : 0);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(FILTER_CYCLES - 1);
  localparam logic [WIN_W-1:0]    WIN_LAST    = WIN_W'(REFCLK_HZ - 1);
  localparam logic [STABLE_W-1:0] STABLE_ONE  = STABLE_W'(1);
  localparam logic [WIN_W-1:0]    WIN_ONE     = WIN_W'(1);

  if (!(PULSES_PER_REV == 1 || PULSES_PER_REV == 2 || PULSES_PER_REV == 4)) begin : g_bad_ppr
    $error("fan_tach_counter: PULSES_PER_REV must be 1, 2 or 4");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("fan_tach_counter: FILTER_CYCLES must be at least 1");
  end
  if (REFCLK_HZ < 1) begin : g_bad_refclk
    $error("fan_tach_counter: REFCLK_HZ must be at least 1");
  end

  logic                sync1_q, sync1_d;
  logic                tach_sync_q, tach_sync_d;
  logic                filt_level_q, filt_level_d;
  logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
  logic                filt_level_dly_q, filt_level_dly_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [15:0]         pulse_cnt_q, pulse_cnt_d;
  logic [23:0]         scaled_q, scaled_d;
  logic                zero_q, zero_d;
  logic                load_q, load_d;
  logic [15:0]         rpm_q, rpm_d;
  logic                stalled_q, stalled_d;
  logic                rpm_valid_q, rpm_valid_d;

  logic                rise;
  logic                win_end;
  logic [15:0]         closing_cnt;
  logic [23:0]         closing_ext;

  always_comb begin
    sync1_d          = tach;
    tach_sync_d      = sync1_q;

    filt_level_d     = filt_level_q;
    stable_cnt_d     = '0;
    if (tach_sync_q != filt_level_q) begin
      if (stable_cnt_q == STABLE_LAST) begin
        filt_level_d = tach_sync_q;
      end else begin
        stable_cnt_d = stable_cnt_q + STABLE_ONE;
      end
    end
    filt_level_dly_d = filt_level_q;
    rise             = filt_level_q & ~filt_level_dly_q;

    win_end          = (win_cnt_q == WIN_LAST);
    win_cnt_d        = win_end ? '0 : (win_cnt_q + WIN_ONE);

    // Saturating increment doubles as the closing count, so a terminal-cycle edge lands in it.
    closing_cnt      = (pulse_cnt_q == 16'hFFFF) ? 16'hFFFF : (pulse_cnt_q + {15'd0, rise});
    pulse_cnt_d      = win_end ? 16'd0 : closing_cnt;
    closing_ext      = {8'd0, closing_cnt};

    scaled_d         = scaled_q;
    zero_d           = zero_q;
    if (win_end) begin
      scaled_d       = ((closing_ext << 6) - (closing_ext << 2)) >> PPR_SHIFT;
      zero_d         = (closing_cnt == 16'd0);
    end
    load_d           = win_end;

    rpm_d            = rpm_q;
    stalled_d        = stalled_q;
    if (load_q) begin
      rpm_d          = (scaled_q > 24'h00FFFF) ? 16'hFFFF : scaled_q[15:0];
      stalled_d      = zero_q;
    end
    rpm_valid_d      = load_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q          <= 1'b1;
      tach_sync_q      <= 1'b1;
      filt_level_q     <= 1'b1;
      stable_cnt_q     <= '0;
      filt_level_dly_q <= 1'b1;
      win_cnt_q        <= '0;
      pulse_cnt_q      <= 16'd0;
      scaled_q         <= 24'd0;
      zero_q           <= 1'b0;
      load_q           <= 1'b0;
      rpm_q            <= 16'd0;
      stalled_q        <= 1'b0;
      rpm_valid_q      <= 1'b0;
    end else begin
      sync1_q          <= sync1_d;
      tach_sync_q      <= tach_sync_d;
      filt_level_q     <= filt_level_d;
      stable_cnt_q     <= stable_cnt_d;
      filt_level_dly_q <= filt_level_dly_d;
      win_cnt_q        <= win_cnt_d;
      pulse_cnt_q      <= pulse_cnt_d;
      scaled_q         <= scaled_d;
      zero_q           <= zero_d;
      load_q           <= load_d;
      rpm_q            <= rpm_d;
      stalled_q        <= stalled_d;
      rpm_valid_q      <= rpm_valid_d;
    end
  end

  assign rpm       = rpm_q;
  assign rpm_valid = rpm_valid_q;
  assign stalled   = stalled_q;

endmodule

`default_nettype wire

// File: tb/tb_fan_tach_counter.sv
// Directed bench for fan_tach_counter: reset/idle, window boundary, pattern table, mid-window reset.
`default_nettype none

module tb_fan_tach_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        man_a, man_b, man_c;
  logic        gen_tach;
  logic        use_gen;
  int          sel;
  int          g_period;
  int          g_low;

  logic        tach_a, tach_b, tach_c;
  logic [15:0] rpm_a, rpm_b, rpm_c;
  logic        valid_a, valid_b, valid_c;
  logic        stalled_a, stalled_b, stalled_c;

  logic [15:0] s_rpm;
  logic        s_valid, s_stalled;

  int cyc = 0;
  int rel = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int sel;
    int period;
    int low;
    int exp_rpm;
    int exp_stalled;
    int win;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tach_a = (use_gen && sel == 0) ? gen_tach : man_a;
  assign tach_b = (use_gen && sel == 1) ? gen_tach : man_b;
  assign tach_c = (use_gen && sel == 2) ? gen_tach : man_c;

  fan_tach_counter #(.REFCLK_HZ(1000), .PULSES_PER_REV(2), .FILTER_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tach(tach_a),
    .rpm(rpm_a), .rpm_valid(valid_a), .stalled(stalled_a));

  fan_tach_counter #(.REFCLK_HZ(1000), .PULSES_PER_REV(1), .FILTER_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tach(tach_b),
    .rpm(rpm_b), .rpm_valid(valid_b), .stalled(stalled_b));

  fan_tach_counter #(.REFCLK_HZ(2400), .PULSES_PER_REV(1), .FILTER_CYCLES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .tach(tach_c),
    .rpm(rpm_c), .rpm_valid(valid_c), .stalled(stalled_c));

  always_comb begin
    s_rpm     = rpm_a;
    s_valid   = valid_a;
    s_stalled = stalled_a;
    case (sel)
      1: begin s_rpm = rpm_b; s_valid = valid_b; s_stalled = stalled_b; end
      2: begin s_rpm = rpm_c; s_valid = valid_c; s_stalled = stalled_c; end
      default: ;
    endcase
  end

  // Periodic tach pattern: g_low cycles low, then high for the rest of g_period.
  initial begin
    int ph;
    ph = 0;
    gen_tach = 1'b1;
    forever begin
      @(negedge clk);
      if (g_period == 0) begin
        gen_tach = 1'b1;
        ph = 0;
      end else begin
        if (ph >= g_period) ph = 0;
        gen_tach = (ph < g_low) ? 1'b0 : 1'b1;
        ph++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle 1 is the cycle in which rst_n was released.
  task automatic to_cycle(input int k);
    while (cyc - rel + 1 < k) @(negedge clk);
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (s_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int c2, c3;

    vecs[0] = '{0, 40, 20,   750, 0, 1000};
    vecs[1] = '{0, 20, 10,  1500, 0, 1000};
    vecs[2] = '{0, 40,  3,     0, 1, 1000};
    vecs[3] = '{0, 40,  4,   750, 0, 1000};
    vecs[4] = '{0,  0,  0,     0, 1, 1000};
    vecs[5] = '{1,  4,  2, 15000, 0, 1000};
    vecs[6] = '{1,  2,  1, 30000, 0, 1000};
    vecs[7] = '{2,  2,  1, 65535, 0, 2400};
    vecs[8] = '{2,  4,  2, 36000, 0, 2400};

    rst_n = 1'b0;
    man_a = 1'b1; man_b = 1'b1; man_c = 1'b1;
    use_gen = 1'b0; sel = 0; g_period = 0; g_low = 0;

    repeat (4) @(negedge clk);
    chk("reset_rpm", int'(rpm_a), 0);
    chk("reset_valid", int'(valid_a), 0);
    chk("reset_stalled", int'(stalled_a), 0);

    // Idle line after reset: first result at cycle 1002, no edge from reset.
    rst_n = 1'b1;
    rel = cyc;
    to_cycle(1001);
    chk("idle_no_early_valid", int'(valid_a), 0);
    to_cycle(1002);
    chk("idle_first_valid", int'(valid_a), 1);
    chk("idle_rpm", int'(rpm_a), 0);
    chk("idle_stalled", int'(stalled_a), 1);
    chk("idle_b_stalled", int'(stalled_b), 1);
    to_cycle(1003);
    chk("idle_valid_one_cycle", int'(valid_a), 0);

    // Rising edge on the win_end cycle (2000) belongs to the closing window.
    to_cycle(1100); man_a = 1'b0;
    to_cycle(1994); man_a = 1'b1;
    to_cycle(2002);
    chk("bnd_end_valid", int'(valid_a), 1);
    chk("bnd_end_rpm", int'(rpm_a), 30);
    chk("bnd_end_stalled", int'(stalled_a), 0);
    to_cycle(3002);
    chk("bnd_end_next_rpm", int'(rpm_a), 0);
    chk("bnd_end_next_stalled", int'(stalled_a), 1);

    // Edge one cycle after win_end (4001) goes to the following window.
    to_cycle(3100); man_a = 1'b0;
    to_cycle(3995); man_a = 1'b1;
    to_cycle(4002);
    chk("bnd_after_rpm", int'(rpm_a), 0);
    chk("bnd_after_stalled", int'(stalled_a), 1);
    to_cycle(5002);
    chk("bnd_after_next_valid", int'(valid_a), 1);
    chk("bnd_after_next_rpm", int'(rpm_a), 30);
    chk("bnd_after_next_stalled", int'(stalled_a), 0);

    // Pattern table: skip two settling windows, check the third.
    use_gen = 1'b1;
    for (int i = 0; i < NV; i++) begin
      sel      = vecs[i].sel;
      g_period = vecs[i].period;
      g_low    = vecs[i].low;
      wait_valid(vecs[i].win + 10, ok);
      chk($sformatf("v%0d_strobe1", i), int'(ok), 1);
      wait_valid(vecs[i].win + 10, ok);
      chk($sformatf("v%0d_strobe2", i), int'(ok), 1);
      c2 = cyc;
      wait_valid(vecs[i].win + 10, ok);
      chk($sformatf("v%0d_strobe3", i), int'(ok), 1);
      c3 = cyc;
      chk($sformatf("v%0d_interval", i), c3 - c2, vecs[i].win);
      chk($sformatf("v%0d_rpm", i), int'(s_rpm), vecs[i].exp_rpm);
      chk($sformatf("v%0d_stalled", i), int'(s_stalled), vecs[i].exp_stalled);
      @(negedge clk);
      chk($sformatf("v%0d_valid_one_cycle", i), int'(s_valid), 0);
    end

    // Reset pulse 500 cycles into a window with edges already counted.
    sel = 0; g_period = 40; g_low = 20;
    wait_valid(1010, ok);
    wait_valid(1010, ok);
    wait_valid(1010, ok);
    chk("mid_pre_strobe", int'(ok), 1);
    chk("mid_pre_rpm", int'(rpm_a), 750);
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    g_period = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    chk("mid_rst_rpm", int'(rpm_a), 0);
    chk("mid_rst_stalled", int'(stalled_a), 0);
    chk("mid_rst_valid", int'(valid_a), 0);
    to_cycle(1001);
    chk("mid_no_early_valid", int'(valid_a), 0);
    to_cycle(1002);
    chk("mid_next_valid", int'(valid_a), 1);
    chk("mid_next_rpm", int'(rpm_a), 0);
    chk("mid_next_stalled", int'(stalled_a), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
